// File: rtl/qspi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : qspi_pkg
// Description : Shared constants, FSM state encoding and CCR word builder
//               for the QSPI execute-in-place read controller.
// Revision    : 1.0 - initial release
// ============================================================================
package qspi_pkg;

    // QSPI master register map (byte offsets on the register port)
    localparam logic [5:0]  c_REG_CCR = 6'h00;
    localparam logic [5:0]  c_REG_ADR = 6'h04;
    localparam logic [5:0]  c_REG_DR0 = 6'h08;
    localparam logic [5:0]  c_REG_STA = 6'h28;

    // Flash command code for a plain read
    localparam logic [7:0]  c_CMD_READ = 8'h03;

    // STA bit 0: low while a transfer runs, high once chip select is released
    localparam int          c_STA_CS_IDLE_BIT = 0;

    // Data returned with an error response
    localparam logic [31:0] c_ERR_DATA = 32'hDEADBEEF;

    // ABORT is only reachable when the poll timeout is compiled in
    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_HIT       = 4'd1,
        ST_WR_ADR    = 4'd2,
        ST_WR_CCR    = 4'd3,
        ST_POLL_BUSY = 4'd4,
        ST_POLL_DONE = 4'd5,
        ST_RD_DR     = 4'd6,
        ST_RESP      = 4'd7,
        ST_ABORT     = 4'd8
    } xip_state_e;

    // CCR layout: [31] abort, [30:25] SCLK divider, [7:0] command
    function automatic logic [31:0] ccr_word(input logic abort, input logic [5:0] div);
        return {abort, div, 17'h0, c_CMD_READ};
    endfunction

endpackage
`default_nettype wire

// File: rtl/qspi_xip_poll_timer.sv
`default_nettype none
// ============================================================================
// Module      : qspi_xip_poll_timer
// Description : Saturating cycle counter bounding the status-poll loop.
//               expired_o is high during the TIMEOUT_CYCLES-th enabled cycle.
//               Instantiated only when QSPI_XIP_TIMEOUT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module qspi_xip_poll_timer #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [c_CNT_W-1:0] count_q;
    logic [c_CNT_W-1:0] count_d;

    assign expired_o = enable_i && (count_q == c_CNT_W'(TIMEOUT_CYCLES - 1));

    // Next count: clear wins, otherwise advance while enabled until expiry
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && !expired_o) begin
            count_d = count_q + 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/qspi_xip_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : qspi_xip_ctrl
// Description : Execute-in-place read front end. Serves 32-bit reads from a
//               one-word buffer, and on a miss drives the QSPI master's
//               register port (ADR, CCR, poll STA, read DR0).
//               Optional: QSPI_XIP_TIMEOUT_EN adds a poll timeout that aborts
//               the transfer and returns an error response.
// Revision    : 1.0 - initial release
// ============================================================================
module qspi_xip_ctrl
    import qspi_pkg::*;
#(
    parameter logic [5:0] CLK_DIV        = 6'd2,
    parameter int          TIMEOUT_CYCLES = 4096
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [23:0] req_addr_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_data_o,
    output logic        rsp_err_o,
    output logic        qspi_write_o,
    output logic [3:0]  qspi_be_o,
    output logic [5:0]  qspi_addr_o,
    output logic [31:0] qspi_wdata_o,
    input  logic [31:0] qspi_rdata_i
);

    xip_state_e  state_q,    state_d;
    logic [21:0] word_q,     word_d;      // word address of the request in flight
    logic [21:0] tag_q,      tag_d;
    logic [31:0] buf_q,      buf_d;
    logic        buf_vld_q,  buf_vld_d;
    logic [31:0] rsp_data_q, rsp_data_d;

    logic        w_hit;
    logic        w_sta_idle;
    logic        w_unused_addr_lsb;

    // Byte lanes within the word are irrelevant: reads are always whole words
    assign w_unused_addr_lsb = ^req_addr_i[1:0];

    assign w_hit      = buf_vld_q && (tag_q == req_addr_i[23:2]);
    assign w_sta_idle = qspi_rdata_i[c_STA_CS_IDLE_BIT];
    assign rsp_data_o = rsp_data_q;

`ifdef QSPI_XIP_TIMEOUT_EN
    logic err_q, err_d;
    logic w_polling;
    logic w_tmo_expired;

    assign w_polling = (state_q == ST_POLL_BUSY) || (state_q == ST_POLL_DONE);
    assign rsp_err_o = (state_q == ST_RESP) && err_q;

    qspi_xip_poll_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_poll_timer (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   (!w_polling),
        .enable_i  (w_polling),
        .expired_o (w_tmo_expired)
    );
`else
    localparam int c_unused_timeout_cycles = TIMEOUT_CYCLES;
    assign rsp_err_o = 1'b0;
`endif

    // Next-state, register-port drive and buffer/response updates
    always_comb begin
        state_d      = state_q;
        word_d       = word_q;
        tag_d        = tag_q;
        buf_d        = buf_q;
        buf_vld_d    = buf_vld_q;
        rsp_data_d   = rsp_data_q;
`ifdef QSPI_XIP_TIMEOUT_EN
        err_d        = err_q;
`endif
        req_ready_o  = 1'b0;
        rsp_valid_o  = 1'b0;
        qspi_write_o = 1'b0;
        qspi_be_o    = 4'h0;
        qspi_addr_o  = 6'h00;
        qspi_wdata_o = 32'h0;

        case (state_q)
            ST_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    word_d = req_addr_i[23:2];
                    if (w_hit) begin
                        rsp_data_d = buf_q;
                        state_d    = ST_HIT;
                    end else begin
                        state_d    = ST_WR_ADR;
                    end
                end
            end
            ST_HIT: begin
                rsp_valid_o = 1'b1;
                state_d     = ST_IDLE;
            end
            ST_WR_ADR: begin
                qspi_write_o = 1'b1;
                qspi_be_o    = 4'hF;
                qspi_addr_o  = c_REG_ADR;
                qspi_wdata_o = {8'h00, word_q, 2'b00};
                state_d      = ST_WR_CCR;
            end
            ST_WR_CCR: begin
                qspi_write_o = 1'b1;
                qspi_be_o    = 4'hF;
                qspi_addr_o  = c_REG_CCR;
                qspi_wdata_o = ccr_word(1'b0, CLK_DIV);
                state_d      = ST_POLL_BUSY;
            end
            ST_POLL_BUSY: begin
                qspi_be_o   = 4'h1;
                qspi_addr_o = c_REG_STA;
                if (!w_sta_idle) begin
                    state_d = ST_POLL_DONE;
                end
`ifdef QSPI_XIP_TIMEOUT_EN
                else if (w_tmo_expired) begin
                    state_d = ST_ABORT;
                end
`endif
            end
            ST_POLL_DONE: begin
                qspi_be_o   = 4'h1;
                qspi_addr_o = c_REG_STA;
                if (w_sta_idle) begin
                    state_d = ST_RD_DR;
                end
`ifdef QSPI_XIP_TIMEOUT_EN
                else if (w_tmo_expired) begin
                    state_d = ST_ABORT;
                end
`endif
            end
            ST_RD_DR: begin
                qspi_be_o   = 4'hF;
                qspi_addr_o = c_REG_DR0;
                buf_d       = qspi_rdata_i;
                tag_d       = word_q;
                buf_vld_d   = 1'b1;
                rsp_data_d  = qspi_rdata_i;
`ifdef QSPI_XIP_TIMEOUT_EN
                err_d       = 1'b0;
`endif
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid_o = 1'b1;
                state_d     = ST_IDLE;
            end
`ifdef QSPI_XIP_TIMEOUT_EN
            ST_ABORT: begin
                qspi_write_o = 1'b1;
                qspi_be_o    = 4'hF;
                qspi_addr_o  = c_REG_CCR;
                qspi_wdata_o = ccr_word(1'b1, CLK_DIV);
                buf_vld_d    = 1'b0;
                rsp_data_d   = c_ERR_DATA;
                err_d        = 1'b1;
                state_d      = ST_RESP;
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, buffer and response registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            word_q     <= '0;
            tag_q      <= '0;
            buf_q      <= '0;
            buf_vld_q  <= 1'b0;
            rsp_data_q <= '0;
`ifdef QSPI_XIP_TIMEOUT_EN
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            tag_q      <= tag_d;
            buf_q      <= buf_d;
            buf_vld_q  <= buf_vld_d;
            rsp_data_q <= rsp_data_d;
`ifdef QSPI_XIP_TIMEOUT_EN
            err_q      <= err_d;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_qspi_xip_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_qspi_xip_ctrl
// Description : Directed self-checking bench for qspi_xip_ctrl with a
//               behavioural QSPI master register model. The timeout scenario
//               is exercised when QSPI_XIP_TIMEOUT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_qspi_xip_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [23:0] req_addr_i;
    logic        rsp_valid_o;
    logic [31:0] rsp_data_o;
    logic        rsp_err_o;
    logic        qspi_write_o;
    logic [3:0]  qspi_be_o;
    logic [5:0]  qspi_addr_o;
    logic [31:0] qspi_wdata_o;
    logic [31:0] qspi_rdata_i;

    int vectors     = 0;
    int miscompares = 0;

    qspi_xip_ctrl #(
        .CLK_DIV        (6'd2),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_addr_i   (req_addr_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_data_o   (rsp_data_o),
        .rsp_err_o    (rsp_err_o),
        .qspi_write_o (qspi_write_o),
        .qspi_be_o    (qspi_be_o),
        .qspi_addr_o  (qspi_addr_o),
        .qspi_wdata_o (qspi_wdata_o),
        .qspi_rdata_i (qspi_rdata_i)
    );

    always #5 clk = ~clk;

    // ---------------- QSPI master model ----------------
    int          busy_cnt    = 0;
    int          busy_len    = 3;
    bit          stuck       = 1'b0;
    bit          dr_from_adr = 1'b0;
    logic [31:0] dr_val      = 32'h0;
    logic [31:0] last_adr    = 32'h0;
    logic        sta0;

    assign sta0 = stuck ? 1'b0 : (busy_cnt == 0);

    // Transfer starts on a non-abort CCR write; CS releases busy_len cycles later
    always @(posedge clk) begin
        if (rst) begin
            busy_cnt <= 0;
        end else begin
            if (qspi_write_o && qspi_addr_o == 6'h04) last_adr <= qspi_wdata_o;
            if (qspi_write_o && qspi_addr_o == 6'h00 && !qspi_wdata_o[31]) busy_cnt <= busy_len;
            else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
        end
    end

    // Combinational register read
    always_comb begin
        qspi_rdata_i = 32'h0;
        case (qspi_addr_o)
            6'h28:   qspi_rdata_i = {31'h0, sta0};
            6'h08:   qspi_rdata_i = dr_from_adr ? {8'hD0, last_adr[23:0]} : dr_val;
            default: qspi_rdata_i = 32'h0;
        endcase
    end

    // ---------------- Monitor ----------------
    int          cyc = 0;
    int          acc_n = 0, rsp_n = 0, wr_n = 0, ccr_n = 0, bad_be = 0, err_seen = 0;
    int          acc_c [0:63];
    int          rsp_c [0:63];
    logic [31:0] rsp_d [0:63];
    logic        rsp_e [0:63];
    logic [31:0] adr_last = 32'h0;
    logic [31:0] ccr_last = 32'h0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (req_valid_i && req_ready_o) begin
                acc_c[acc_n] <= cyc;
                acc_n        <= acc_n + 1;
            end
            if (rsp_valid_o) begin
                rsp_c[rsp_n] <= cyc;
                rsp_d[rsp_n] <= rsp_data_o;
                rsp_e[rsp_n] <= rsp_err_o;
                rsp_n        <= rsp_n + 1;
                if (rsp_err_o) err_seen <= err_seen + 1;
            end
            if (qspi_write_o) begin
                wr_n <= wr_n + 1;
                if (qspi_be_o != 4'hF) bad_be <= bad_be + 1;
                if (qspi_addr_o == 6'h04) adr_last <= qspi_wdata_o;
                if (qspi_addr_o == 6'h00) begin
                    ccr_last <= qspi_wdata_o;
                    ccr_n    <= ccr_n + 1;
                end
            end else begin
                if (qspi_addr_o == 6'h28 && qspi_be_o != 4'h1) bad_be <= bad_be + 1;
                if (qspi_addr_o == 6'h08 && qspi_be_o != 4'hF) bad_be <= bad_be + 1;
            end
        end
    end

    // ---------------- Helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [23:0] a);
        int t  = 0;
        int n0 = acc_n;
        req_valid_i = 1'b1;
        req_addr_i  = a;
        while (acc_n == n0 && t < 300) begin
            step(1);
            t++;
        end
        req_valid_i = 1'b0;
        chk("accepted", 32'(acc_n != n0), 32'd1);
    endtask

    task automatic wait_rsp(input int target, input string tag);
        int t = 0;
        while (rsp_n < target && t < 300) begin
            step(1);
            t++;
        end
        chk(tag, 32'(rsp_n >= target), 32'd1);
    endtask

    // Global bound so the run always terminates
    initial begin
        #400000;
        $display("FAIL watchdog expired vectors=%0d", vectors);
        $fatal(1, "watchdog");
    end

    // ---------------- Directed sequence ----------------
    initial begin
        int na, nr, nw, nc, t;
        rst         = 1'b1;
        req_valid_i = 1'b0;
        req_addr_i  = 24'h0;
        step(3);

        // Reset state
        chk("rst_ready",    32'(req_ready_o),  32'd1);
        chk("rst_rsp_vld",  32'(rsp_valid_o),  32'd0);
        chk("rst_rsp_err",  32'(rsp_err_o),    32'd0);
        chk("rst_write",    32'(qspi_write_o), 32'd0);
        chk("rst_be",       32'(qspi_be_o),    32'd0);
        chk("rst_rsp_data", rsp_data_o,        32'h0);
        rst = 1'b0;
        step(2);

        // Cold miss
        dr_val = 32'hA5A55A5A;
        nr = rsp_n; nw = wr_n;
        send(24'h000104);
        wait_rsp(nr + 1, "cold_rsp");
        chk("cold_adr_wdata", adr_last,        32'h00000104);
        chk("cold_ccr_wdata", ccr_last,        32'h04000003);
        chk("cold_data",      rsp_d[nr],       32'hA5A55A5A);
        chk("cold_err",       32'(rsp_e[nr]),  32'd0);
        chk("cold_writes",    32'(wr_n - nw),  32'd2);
        step(3);
        chk("data_stable",    rsp_data_o,      32'hA5A55A5A);

        // Hit on same word, different byte offset
        dr_val = 32'h0BAD0BAD;
        na = acc_n; nr = rsp_n; nw = wr_n;
        send(24'h000106);
        wait_rsp(nr + 1, "hit_rsp");
        chk("hit_data",    rsp_d[nr],                 32'hA5A55A5A);
        chk("hit_latency", 32'(rsp_c[nr] - acc_c[na]), 32'd1);
        chk("hit_writes",  32'(wr_n - nw),            32'd0);

        // Different word: full miss, buffer retagged
        dr_val = 32'h12345678;
        nr = rsp_n; nw = wr_n;
        send(24'h000108);
        wait_rsp(nr + 1, "word2_rsp");
        chk("word2_adr_wdata", adr_last,       32'h00000108);
        chk("word2_data",      rsp_d[nr],      32'h12345678);
        chk("word2_writes",    32'(wr_n - nw), 32'd2);
        na = acc_n; nr = rsp_n; nw = wr_n;
        send(24'h00010B);
        wait_rsp(nr + 1, "retag_rsp");
        chk("retag_data",    rsp_d[nr],                 32'h12345678);
        chk("retag_latency", 32'(rsp_c[nr] - acc_c[na]), 32'd1);
        chk("retag_writes",  32'(wr_n - nw),            32'd0);

        // Reset while waiting for chip-select release
        busy_len = 20;
        dr_val   = 32'hCAFEF00D;
        nr = rsp_n; nc = ccr_n;
        send(24'h000104);
        t = 0;
        while (ccr_n == nc && t < 100) begin
            step(1);
            t++;
        end
        step(3);
        chk("midpoll_reading_sta", 32'(qspi_addr_o), 32'h28);
        rst = 1'b1;
        step(1);
        chk("midpoll_ready",  32'(req_ready_o),  32'd1);
        chk("midpoll_write",  32'(qspi_write_o), 32'd0);
        rst = 1'b0;
        step(30);
        chk("midpoll_no_rsp", 32'(rsp_n - nr), 32'd0);
        busy_len = 3;
        nr = rsp_n; nw = wr_n;
        send(24'h000104);
        wait_rsp(nr + 1, "postrst_rsp");
        chk("postrst_writes", 32'(wr_n - nw), 32'd2);
        chk("postrst_data",   rsp_d[nr],      32'hCAFEF00D);

        // Back-to-back: valid held across two different words
        dr_from_adr = 1'b1;
        na = acc_n; nr = rsp_n;
        req_valid_i = 1'b1;
        req_addr_i  = 24'h000200;
        t = 0;
        while (acc_n == na && t < 300) begin
            step(1);
            t++;
        end
        req_addr_i = 24'h000300;
        t = 0;
        while (acc_n < na + 2 && t < 300) begin
            step(1);
            t++;
        end
        req_valid_i = 1'b0;
        chk("b2b_both_accepted", 32'(acc_n - na), 32'd2);
        wait_rsp(nr + 2, "b2b_rsp");
        chk("b2b_first_data",  rsp_d[nr],     32'hD0000200);
        chk("b2b_second_data", rsp_d[nr + 1], 32'hD0000300);
        chk("b2b_accept_after_resp", 32'(acc_c[na + 1] - rsp_c[nr]), 32'd1);
        dr_from_adr = 1'b0;

`ifdef QSPI_XIP_TIMEOUT_EN
        // Poll timeout: STA[0] stuck low
        stuck = 1'b1;
        nr = rsp_n; nc = ccr_n;
        send(24'h000400);
        wait_rsp(nr + 1, "tmo_rsp");
        chk("tmo_ccr_writes", 32'(ccr_n - nc), 32'd2);
        chk("tmo_abort_ccr",  ccr_last,        32'h84000003);
        chk("tmo_err",        32'(rsp_e[nr]),  32'd1);
        chk("tmo_data",       rsp_d[nr],       32'hDEADBEEF);
        stuck  = 1'b0;
        dr_val = 32'h01020304;
        nr = rsp_n; nw = wr_n;
        send(24'h000400);
        wait_rsp(nr + 1, "tmo_retry_rsp");
        chk("tmo_retry_writes", 32'(wr_n - nw),  32'd2);
        chk("tmo_retry_err",    32'(rsp_e[nr]),  32'd0);
        chk("tmo_retry_data",   rsp_d[nr],       32'h01020304);
`else
        chk("no_err_responses", 32'(err_seen), 32'd0);
`endif

        chk("byte_enables", 32'(bad_be), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
